tmvp2: RTL and testbench



---
 rtl/tmvp_pkg.sv | 15 +
 rtl/tmvp2_addr_gen.sv | 118 +++++++++++
 rtl/tmvp2.sv | 151 +++++++++++++++
 tb/tb_tmvp2.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmvp_pkg.sv
// Shared types and helpers for the Toeplitz matrix-vector product engine.
package tmvp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    // Address width needed to index an N-element operand.
    function automatic int unsigned aw_of(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/tmvp2_addr_gen.sv
// Address sequencer: walks (i, k) over the N x N/2 pair grid and maps each
// matrix element onto the row or column memory.
module tmvp2_addr_gen
    import tmvp_pkg::*;
#(
    parameter int unsigned N = 32,
    localparam int unsigned AW = aw_of(N)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          launch_i,
    output logic [AW-1:0] addr_1_o,
    output logic [AW-1:0] addr_2_o,
    output logic          is_row_1_o,
    output logic          is_row_2_o,
    output logic [AW-1:0] vec_1_o,
    output logic [AW-1:0] vec_2_o,
    output logic          valid_o,
    output logic          last_o
);

    localparam int unsigned KW = AW - 1;
    localparam logic [KW-1:0] KLast = KW'(N / 2 - 1);
    localparam logic [AW-1:0] ILast = AW'(N - 1);

    logic [AW-1:0] i_q, i_d;
    logic [KW-1:0] k_q, k_d;
    logic          valid_q, valid_d;
    logic [AW-1:0] addr_1_q, addr_1_d, addr_2_q, addr_2_d;
    logic          is_row_1_q, is_row_1_d, is_row_2_q, is_row_2_d;
    logic [AW-1:0] vec_1_q, vec_1_d, vec_2_q, vec_2_d;
    logic [AW-1:0] j_1, j_2;

    assign last_o = valid_q && (i_q == ILast) && (k_q == KLast);

    always_comb begin
        i_d     = i_q;
        k_d     = k_q;
        valid_d = valid_q;
        if (launch_i) begin
            i_d     = '0;
            k_d     = '0;
            valid_d = 1'b1;
        end else if (valid_q) begin
            if (last_o) begin
                i_d     = '0;
                k_d     = '0;
                valid_d = 1'b0;
            end else if (k_q == KLast) begin
                k_d = '0;
                i_d = i_q + 1'b1;
            end else begin
                k_d = k_q + 1'b1;
            end
        end
    end

    // Map the next (i, j) pair so the registered addresses line up with valid_q.
    always_comb begin
        j_1        = {k_d, 1'b0};
        j_2        = {k_d, 1'b1};
        addr_1_d   = '0;
        addr_2_d   = '0;
        is_row_1_d = 1'b0;
        is_row_2_d = 1'b0;
        vec_1_d    = '0;
        vec_2_d    = '0;
        if (valid_d) begin
            if (j_1 >= i_d) begin
                is_row_1_d = 1'b1;
                addr_1_d   = j_1 - i_d;
            end else begin
                addr_1_d = i_d - j_1;
            end
            if (j_2 >= i_d) begin
                is_row_2_d = 1'b1;
                addr_2_d   = j_2 - i_d;
            end else begin
                addr_2_d = i_d - j_2;
            end
            vec_1_d = j_1;
            vec_2_d = j_2;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            i_q        <= '0;
            k_q        <= '0;
            valid_q    <= 1'b0;
            addr_1_q   <= '0;
            addr_2_q   <= '0;
            is_row_1_q <= 1'b0;
            is_row_2_q <= 1'b0;
            vec_1_q    <= '0;
            vec_2_q    <= '0;
        end else begin
            i_q        <= i_d;
            k_q        <= k_d;
            valid_q    <= valid_d;
            addr_1_q   <= addr_1_d;
            addr_2_q   <= addr_2_d;
            is_row_1_q <= is_row_1_d;
            is_row_2_q <= is_row_2_d;
            vec_1_q    <= vec_1_d;
            vec_2_q    <= vec_2_d;
        end
    end

    assign addr_1_o   = addr_1_q;
    assign addr_2_o   = addr_2_q;
    assign is_row_1_o = is_row_1_q;
    assign is_row_2_o = is_row_2_q;
    assign vec_1_o    = vec_1_q;
    assign vec_2_o    = vec_2_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/tmvp2.sv
// Toeplitz matrix-vector product engine: two MAC lanes fed from external
// row/column/vector memories, results streamed out in order.
module tmvp2
    import tmvp_pkg::*;
#(
    parameter int unsigned N          = 32,
    parameter int unsigned DATA_WIDTH = 8,
    localparam int unsigned AW        = aw_of(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  ready,
    output logic [AW-1:0]         address_1,
    output logic [AW-1:0]         address_2,
    output logic                  address_1_isRow,
    output logic                  address_2_isRow,
    output logic                  address_row_valid,
    output logic [AW-1:0]         address_vec_1,
    output logic [AW-1:0]         address_vec_2,
    output logic                  address_vec_valid,
    input  logic [DATA_WIDTH-1:0] data_row_data_1,
    input  logic [DATA_WIDTH-1:0] data_row_data_2,
    input  logic                  data_row_valid,
    input  logic [DATA_WIDTH-1:0] data_vec_data_1,
    input  logic [DATA_WIDTH-1:0] data_vec_data_2,
    input  logic                  data_vec_valid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid
);

    localparam int unsigned PW = AW - 1;
    localparam logic [PW-1:0] PairLast = PW'(N / 2 - 1);
    localparam logic [AW-1:0] IdxLast  = AW'(N - 1);

    state_e                state_q, state_d;
    logic                  ready_q;
    logic                  launch;
    logic                  addr_valid;
    logic                  addr_last;
    logic                  accept;
    logic [DATA_WIDTH-1:0] prod_1, prod_2, sum;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [PW-1:0]         pair_q, pair_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  last_q, last_d;

    tmvp2_addr_gen #(
        .N (N)
    ) u_addr_gen (
        .clk_i      (clk),
        .rst_ni     (reset),
        .launch_i   (launch),
        .addr_1_o   (address_1),
        .addr_2_o   (address_2),
        .is_row_1_o (address_1_isRow),
        .is_row_2_o (address_2_isRow),
        .vec_1_o    (address_vec_1),
        .vec_2_o    (address_vec_2),
        .valid_o    (addr_valid),
        .last_o     (addr_last)
    );

    assign address_row_valid = addr_valid;
    assign address_vec_valid = addr_valid;

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    launch  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (addr_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (last_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Idle gating keeps stray memory responses from leaking into a fresh run.
    assign accept = data_row_valid && data_vec_valid && (state_q != StIdle);
    assign prod_1 = data_row_data_1 * data_vec_data_1;
    assign prod_2 = data_row_data_2 * data_vec_data_2;
    assign sum    = acc_q + prod_1 + prod_2;

    always_comb begin
        acc_d    = acc_q;
        pair_d   = pair_q;
        idx_d    = idx_q;
        tdata_d  = tdata_q;
        tvalid_d = 1'b0;
        last_d   = 1'b0;
        if (launch) begin
            acc_d  = '0;
            pair_d = '0;
            idx_d  = '0;
        end else if (accept) begin
            if (pair_q == PairLast) begin
                tdata_d  = sum;
                tvalid_d = 1'b1;
                acc_d    = '0;
                pair_d   = '0;
                idx_d    = idx_q + 1'b1;
                last_d   = (idx_q == IdxLast);
            end else begin
                acc_d  = sum;
                pair_d = pair_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            ready_q  <= 1'b1;
            acc_q    <= '0;
            pair_q   <= '0;
            idx_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= (state_d == StIdle);
            acc_q    <= acc_d;
            pair_q   <= pair_d;
            idx_q    <= idx_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            last_q   <= last_d;
        end
    end

    assign ready         = ready_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_tmvp2.sv
// Directed bench for tmvp2 with a one-cycle-latency memory model and an
// expected-result queue filled from a direct Toeplitz product.
module tb_tmvp2;

    localparam int N  = 32;
    localparam int DW = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          ready;
    logic [AW-1:0] address_1, address_2, address_vec_1, address_vec_2;
    logic          address_1_isRow, address_2_isRow;
    logic          address_row_valid, address_vec_valid;
    logic [DW-1:0] data_row_data_1, data_row_data_2;
    logic [DW-1:0] data_vec_data_1, data_vec_data_2;
    logic          data_row_valid, data_vec_valid;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;

    logic [DW-1:0] row_m [N];
    logic [DW-1:0] col_m [N];
    logic [DW-1:0] vec_m [N];
    logic [DW-1:0] exp_q [$];

    int n_checks = 0;
    int n_err    = 0;
    int n_out    = 0;
    int n_addr   = 0;

    tmvp2 #(
        .N          (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .ready             (ready),
        .address_1         (address_1),
        .address_2         (address_2),
        .address_1_isRow   (address_1_isRow),
        .address_2_isRow   (address_2_isRow),
        .address_row_valid (address_row_valid),
        .address_vec_1     (address_vec_1),
        .address_vec_2     (address_vec_2),
        .address_vec_valid (address_vec_valid),
        .data_row_data_1   (data_row_data_1),
        .data_row_data_2   (data_row_data_2),
        .data_row_valid    (data_row_valid),
        .data_vec_data_1   (data_vec_data_1),
        .data_vec_data_2   (data_vec_data_2),
        .data_vec_valid    (data_vec_valid),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories, one cycle of latency.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_row_valid  <= 1'b0;
            data_vec_valid  <= 1'b0;
            data_row_data_1 <= '0;
            data_row_data_2 <= '0;
            data_vec_data_1 <= '0;
            data_vec_data_2 <= '0;
        end else begin
            data_row_valid  <= address_row_valid;
            data_vec_valid  <= address_vec_valid;
            data_row_data_1 <= address_1_isRow ? row_m[address_1] : col_m[address_1];
            data_row_data_2 <= address_2_isRow ? row_m[address_2] : col_m[address_2];
            data_vec_data_1 <= vec_m[address_vec_1];
            data_vec_data_2 <= vec_m[address_vec_2];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (address_row_valid) n_addr++;
            if (m_axis_tvalid) begin
                n_out++;
                check("queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    check($sformatf("y[%0d]", n_out - 1), 64'(m_axis_tdata),
                          64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic push_model();
        logic [DW-1:0]   acc;
        logic [DW-1:0]   t;
        logic [2*DW-1:0] p;
        for (int i = 0; i < N; i++) begin
            acc = '0;
            for (int j = 0; j < N; j++) begin
                t   = (j >= i) ? row_m[j-i] : col_m[i-j];
                p   = t * vec_m[j];
                acc = acc + p[DW-1:0];
            end
            exp_q.push_back(acc);
        end
    endtask

    task automatic fill(input logic [DW-1:0] r, input logic [DW-1:0] c, input logic [DW-1:0] v);
        for (int i = 0; i < N; i++) begin
            row_m[i] = r;
            col_m[i] = c;
            vec_m[i] = v;
        end
    endtask

    task automatic check_first(input string tag);
        check({tag, "_ready_low"}, 64'(ready), 64'd0);
        check({tag, "_first_addr"},
              64'({address_1, address_1_isRow, address_2, address_2_isRow,
                   address_vec_1, address_vec_2, address_row_valid, address_vec_valid}),
              64'({5'd0, 1'b1, 5'd1, 1'b1, 5'd0, 5'd1, 1'b1, 1'b1}));
    endtask

    // Drives start immediately; caller guarantees ready is high.
    task automatic start_run(input string tag);
        push_model();
        n_out  = 0;
        n_addr = 0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_first(tag);
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (!ready && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_in_time"}, 64'(cyc < 3000), 64'd1);
        check({tag, "_n_out"}, 64'(n_out), 64'(N));
        check({tag, "_n_addr"}, 64'(n_addr), 64'(N * N / 2));
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_ready"}, 64'(ready), 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 64'(ready), 64'd1);
        check({tag, "_addr"},
              64'({address_1, address_1_isRow, address_2, address_2_isRow,
                   address_vec_1, address_vec_2, address_row_valid, address_vec_valid}),
              64'd0);
        check({tag, "_tdata"}, 64'(m_axis_tdata), 64'd0);
        check({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    endtask

    initial begin
        int cyc;
        reset = 1'b0;
        start = 1'b0;

        // Identity matrix, start held across reset release.
        fill(8'h00, 8'h00, 8'h00);
        row_m[0] = 8'h01;
        col_m[0] = 8'h01;
        for (int j = 0; j < N; j++) vec_m[j] = 8'(j);
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        push_model();
        n_out  = 0;
        n_addr = 0;
        start  = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_first("ident");
        wait_done("ident");

        // Back-to-back starts land on the cycle ready rises.
        fill(8'h01, 8'h01, 8'h01);
        start_run("ones");
        wait_done("ones");

        fill(8'hFF, 8'hFF, 8'hFF);
        start_run("wrap");
        wait_done("wrap");

        fill(8'h00, 8'h00, 8'h00);
        row_m[1] = 8'h01;
        for (int j = 0; j < N; j++) vec_m[j] = 8'($urandom);
        start_run("super");
        wait_done("super");

        fill(8'h00, 8'h00, 8'h00);
        col_m[1] = 8'h01;
        for (int j = 0; j < N; j++) vec_m[j] = 8'($urandom);
        start_run("sub");
        wait_done("sub");

        // Random operands with spurious starts during RUN.
        for (int j = 0; j < N; j++) begin
            row_m[j] = 8'($urandom);
            col_m[j] = 8'($urandom);
            vec_m[j] = 8'($urandom);
        end
        start_run("rand");
        repeat (40) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("rand");

        // Reset mid-run, then a clean rerun.
        start_run("mid");
        cyc = 0;
        while (n_out < 5 && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("mid_reached", 64'(n_out >= 5), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        exp_q.delete();
        n_out  = 0;
        n_addr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("no_partial_out", 64'(n_out), 64'd0);
        check("no_partial_addr", 64'(n_addr), 64'd0);
        for (int j = 0; j < N; j++) begin
            row_m[j] = 8'($urandom);
            col_m[j] = 8'($urandom);
            vec_m[j] = 8'($urandom);
        end
        start_run("rerun");
        wait_done("rerun");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
